// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder slice:
//   state_t   - FSM state encoding of serial_add_sequencer
//   cnt_width - width of the bit counter for a given operand width,
//               $clog2(width) clamped to at least 1 so WIDTH=1 still
//               gets a legal one-bit counter.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// serial_fa_bit
// One-bit full adder with a registered carry, used one bit per cycle.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the carry
//   clr   - synchronous carry clear (start of a new operation)
//   en    - advance: capture the carry produced by this cycle's bits
//   a, b  - operand bits for the current position
//   sum   - combinational sum bit for the current position
//   carry - registered carry into the current position
module serial_fa_bit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  logic half_sum;
  logic carry_next;

  // Gate-level full adder: only XOR/AND/OR are used.
  assign half_sum   = a ^ b;
  assign sum        = half_sum ^ carry;
  assign carry_next = (a & b) | (carry & half_sum);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= carry_next;
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Adds two WIDTH-bit operands one bit per cycle, LSB first, through a
// single registered-carry full adder. One operation takes WIDTH shift
// cycles; the result is then held until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. The producer holds valid and data stable until
// that edge; in_ready never depends on in_valid and out_valid never
// depends on out_ready.
//
// Build option: define SERIAL_ADD_CARRY_OUT_EN to add the cout port
// (final carry, held with sum); otherwise the final carry is dropped.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   in_valid/in_ready   - operand handshake (accepted only in IDLE)
//   a, b                - operands
//   out_valid/out_ready - result handshake (result held in DONE)
//   sum                 - (a + b) mod 2^WIDTH
//   cout                - final carry (only with SERIAL_ADD_CARRY_OUT_EN)
//   busy                - high in SHIFT and DONE
//   state_dbg           - current FSM state (state_t encoding)
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_CARRY_OUT_EN
  output logic             cout,
`endif
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic shift_en;
  logic last_bit;
  logic fa_sum;
  logic fa_carry;

  // Outputs are forced low while rst is asserted, not only after the
  // reset edge has been seen.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE) && !rst;
  assign busy      = (state_q != ST_IDLE) && !rst;
  assign sum       = rst ? '0 : sum_q;
  assign state_dbg = state_q;

  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == CNT_LAST);

  // Carry is cleared on every acceptance so nothing leaks between
  // operations.
  serial_fa_bit u_fa (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (shift_en),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

`ifdef SERIAL_ADD_CARRY_OUT_EN
  // After the last shift the carry register holds the final carry and
  // stays put in DONE because the adder is only enabled in SHIFT.
  assign cout = rst ? 1'b0 : fa_carry;
`endif

  // Each new sum bit enters at the MSB; after WIDTH shifts bit 0 of the
  // result has walked down to position 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_sum;
    end else begin : g_sum_wn
      assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sum_q <= sum_shift;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SERIAL_ADD_CARRY_OUT_EN
  // Final carry is intentionally dropped in this build.
  logic unused_carry;
  assign unused_carry = fa_carry;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer
// Bench for serial_add_sequencer: WIDTH=8 instance driven by directed
// and random operations, checked against an arithmetic reference, plus
// a WIDTH=1 instance for the minimum-width case.
// Honours SERIAL_ADD_CARRY_OUT_EN (cout checked only when defined).
module tb_serial_add_sequencer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (WIDTH=8) ----------------
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b, sum;
  logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_CARRY_OUT_EN
  logic         cout;
`endif

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADD_CARRY_OUT_EN
    .cout      (cout),
`endif
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- DUT (WIDTH=1) ----------------
  logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] state_dbg1;
`ifdef SERIAL_ADD_CARRY_OUT_EN
  logic       cout1;
`endif

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
`ifdef SERIAL_ADD_CARRY_OUT_EN
    .cout      (cout1),
`endif
    .busy      (busy1),
    .state_dbg (state_dbg1)
  );

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];   // {carry, sum} per accepted operation
  int         acc_q[$];   // edge index of each acceptance
  int         total = 0;
  int         bad = 0;
  int         last_acc = 0;
  int         rdy_mode = 0;  // 0: ready high, 1: random, 2: held low

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain addition, carry is bit W.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // ---------------- consumer ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          // Acceptance is edge 0; out_valid must be seen at edge W+1.
          chk("latency_edges", cyc + 1 - acc_q[0], W + 1);
        end
      end
      if (out_valid && exp_q.size() > 0) begin
        chk("sum", sum, exp_q[0][W-1:0]);
`ifdef SERIAL_ADD_CARRY_OUT_EN
        chk("cout", cout, exp_q[0][W]);
`endif
        chk("in_ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents operands and returns just after the accepting edge with
  // in_valid still high, so a following send() keeps in_valid asserted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_add(x, y));
      acc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int first_acc;
    logic [W-1:0] x, y;

    in_valid = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
`ifdef SERIAL_ADD_CARRY_OUT_EN
    chk("rst_cout", cout, 0);
`endif
    chk("rst_in_ready_w1", in_ready1, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Basic add and latency
    send(8'h03, 8'h05);
    idle(1);
    drain();

    // Overflow wraps
    send(8'hFF, 8'h01);
    idle(1);
    drain();

    // Carry isolation, in_valid held across the first operation
    send(8'h80, 8'h80);
    first_acc = last_acc;
    send(8'h01, 8'h01);
    chk("b2b_period", last_acc - first_acc, W + 2);
    idle(1);
    drain();

    // Backpressure: ready low for 5 cycles in DONE
    rdy_mode = 2;
    @(negedge clk);
    send(8'h5A, 8'h33);
    idle(1);
    repeat (W + 1) @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 8'h8D);
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    drain();

    // Abort in SHIFT
    send(8'h55, 8'hAA);
    repeat (4) @(negedge clk);
    chk("abort_busy_shift", busy, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("abort_rst_in_ready", in_ready, 0);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_sum", sum, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_release", in_ready, 1);
    repeat (W + 4) begin
      @(negedge clk);
      chk("abort_no_out_valid", out_valid, 0);
    end
    send(8'h10, 8'h20);
    idle(1);
    drain();

    // Random operations with random backpressure and gaps
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: begin x = 8'hFF; y = 8'hFF; end
        1: begin x = 8'h00; y = 8'h00; end
        2: begin x = 8'h80; y = 8'h80; end
        default: begin x = W'($urandom); y = W'($urandom); end
      endcase
      send(x, y);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    rdy_mode = 0;

    // Minimum width: WIDTH=1, 1+1
    @(negedge clk);
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    chk("w1_in_ready", in_ready1, 1);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("w1_out_valid_edge1", out_valid1, 0);
    @(negedge clk);
    chk("w1_out_valid_edge2", out_valid1, 1);
    chk("w1_sum", sum1, 0);
`ifdef SERIAL_ADD_CARRY_OUT_EN
    chk("w1_cout", cout1, 1);
`endif
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("w1_out_valid_after", out_valid1, 0);
    chk("w1_in_ready_after", in_ready1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
